// File: rtl/bsg_manycore_tile_event_capture.sv
// Per-tile event recorder: packs link handshakes, xbar write grants and bank
// conflicts into timestamped records held in a circular buffer, drained via valid/yumi.
module bsg_manycore_tile_event_capture #(
  parameter int els_p         = 32,
  parameter int stamp_width_p = 16,
  localparam int ptr_width_lp = $clog2(els_p),
  localparam int rec_width_lp = stamp_width_p + 10
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    freeze_i,
  input  logic                    arm_i,
  input  logic [8:0]              trig_mask_i,
  input  logic [ptr_width_lp:0]   post_count_i,
  input  logic                    fwd_in_v_i,
  input  logic                    fwd_in_ready_i,
  input  logic                    fwd_out_v_i,
  input  logic                    fwd_out_ready_i,
  input  logic                    rev_in_v_i,
  input  logic                    rev_in_ready_i,
  input  logic                    rev_out_v_i,
  input  logic                    rev_out_ready_i,
  input  logic [2:0]              xbar_v_i,
  input  logic [2:0]              xbar_yumi_i,
  input  logic [2:0]              xbar_we_i,
  output logic                    v_o,
  output logic [rec_width_lp-1:0] data_o,
  input  logic                    yumi_i,
  output logic [ptr_width_lp:0]   count_o,
  output logic [1:0]              state_o,
  output logic [15:0]             drops_o
);

  typedef enum logic [1:0] {
    e_idle    = 2'd0,
    e_armed   = 2'd1,
    e_run     = 2'd2,
    e_stopped = 2'd3
  } state_e;

  state_e                  state_r, state_n;
  logic [8:0]              events;
  logic [stamp_width_p-1:0] stamp_r;
  logic [ptr_width_lp-1:0] wptr_r, rptr_r;
  logic [ptr_width_lp:0]   count_r;
  logic [ptr_width_lp:0]   post_cnt_r, post_cnt_inc;
  logic [15:0]             drops_r;
  logic                    drop_flag_r;
  logic                    capture, full, wr_ok, wr_drop, rd, post_hit;
  logic [rec_width_lp-1:0] mem_r [els_p];

  always_comb begin
    events      = '0;
    events[0]   = fwd_in_v_i  & fwd_in_ready_i;
    events[1]   = fwd_out_v_i & fwd_out_ready_i;
    events[2]   = rev_in_v_i  & rev_in_ready_i;
    events[3]   = rev_out_v_i & rev_out_ready_i;
    events[4]   = xbar_we_i[1] & xbar_yumi_i[1];
    events[5]   = xbar_we_i[2] & xbar_yumi_i[2];
    events[8:6] = xbar_v_i & ~xbar_yumi_i;
  end

  // The trigger cycle in Armed is itself captured, so capture covers both states.
  assign capture = ~freeze_i & (|events)
                 & ((state_r == e_run) | ((state_r == e_armed) & (|(events & trig_mask_i))));
  assign full    = (count_r == (ptr_width_lp+1)'(els_p));
  assign rd      = yumi_i & v_o;
  assign wr_ok   = capture & (~full | rd);
  assign wr_drop = capture & ~wr_ok;

  assign post_cnt_inc = post_cnt_r + 1'b1;
  assign post_hit     = wr_ok & (post_count_i != '0) & (post_cnt_inc == post_count_i);

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      e_idle:    if (arm_i) state_n = e_armed;
      e_armed:   if (capture) state_n = post_hit ? e_stopped : e_run;
      e_run:     if (post_hit) state_n = e_stopped;
      e_stopped: if (arm_i) state_n = e_armed;
      default:   state_n = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= e_idle;
      stamp_r     <= '0;
      wptr_r      <= '0;
      rptr_r      <= '0;
      count_r     <= '0;
      post_cnt_r  <= '0;
      drops_r     <= '0;
      drop_flag_r <= 1'b0;
    end else begin
      state_r <= state_n;
      stamp_r <= stamp_r + 1'b1;
      if (wr_ok) wptr_r <= wptr_r + 1'b1;
      if (rd)    rptr_r <= rptr_r + 1'b1;
      case ({wr_ok, rd})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
      if ((state_n == e_armed) && (state_r != e_armed)) post_cnt_r <= '0;
      else if (wr_ok) post_cnt_r <= post_cnt_inc;
      if (wr_ok) drop_flag_r <= 1'b0;
      else if (wr_drop) drop_flag_r <= 1'b1;
      if (wr_drop && (drops_r != '1)) drops_r <= drops_r + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_r[wptr_r] <= {stamp_r, drop_flag_r, events};
  end

  assign v_o     = (count_r != '0);
  assign data_o  = mem_r[rptr_r];
  assign count_o = count_r;
  assign state_o = state_r;
  assign drops_o = drops_r;

endmodule
